// File: rtl/operand_entry.sv
// operand_entry: debounced push-button capture of two 16-bit switch operands with a valid/ack handoff.
// Define OPERAND_ENTRY_DEBOUNCE_EN to include the debouncer; otherwise a bare rising-edge detector is used.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        CLK100MHZ,
  input  logic        Reset,
  input  logic [15:0] SW,
  input  logic        Center,
  input  logic        Ack,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic        Valid,
  output logic [3:0]  LED
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    VALID  = 2'd2
  } state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("operand_entry: DEBOUNCE_CYCLES must be at least 2");
  end

  state_t      state_q, state_d;
  logic        sync0_q, s_q;
  logic        press_q, press_d;
  logic        deb_s;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        valid_q, valid_d;
  logic [2:0]  led_q, led_d;

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      sync0_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync0_q <= Center;
      s_q     <= sync0_q;
    end
  end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  // Level changes are accepted only after a full run of differing samples; press marks the 0->1 flip.
  always_comb begin
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    press_d = 1'b0;
    if (s_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d   = s_q;
      cnt_d   = '0;
      press_d = s_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Debouncer state.
  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb_s = deb_q;
`else
  logic s_dly_q;

  // One-cycle delay of the synchronized level for edge detection.
  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      s_dly_q <= 1'b0;
    end else begin
      s_dly_q <= s_q;
    end
  end

  assign press_d = s_q & ~s_dly_q;
  assign deb_s   = s_q;
`endif

  // Entry sequencing: A on the first press, B on the second, then hold until acknowledged.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      WAIT_A: begin
        if (press_q) begin
          a_d     = SW;
          state_d = WAIT_B;
        end else begin
          state_d = WAIT_A;
        end
      end
      WAIT_B: begin
        if (press_q) begin
          b_d     = SW;
          state_d = VALID;
        end else begin
          state_d = WAIT_B;
        end
      end
      VALID: begin
        // Ack wins over a coincident press; the press is discarded.
        if (Ack) begin
          state_d = WAIT_A;
        end else begin
          state_d = VALID;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase
  end

  // Status outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    valid_d = 1'b0;
    led_d   = 3'b001;
    case (state_d)
      WAIT_A:  led_d = 3'b001;
      WAIT_B:  led_d = 3'b010;
      VALID: begin
        led_d   = 3'b100;
        valid_d = 1'b1;
      end
      default: led_d = 3'b001;
    endcase
  end

  // State, operand and status registers.
  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      state_q <= WAIT_A;
      press_q <= 1'b0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      valid_q <= 1'b0;
      led_q   <= 3'b001;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      led_q   <= led_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign Valid = valid_q;
  assign LED   = {deb_s, led_q};

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: history-based reference model checked every cycle, plus directed literal checks.
module tb_operand_entry;

  localparam int D = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
  localparam int CAP    = 3 + D;
`else
  localparam bit DEB_EN = 1'b0;
  localparam int CAP    = 4;
`endif

  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] SW;
  logic        Center;
  logic        Ack;
  logic [15:0] A;
  logic [15:0] B;
  logic        Valid;
  logic [3:0]  LED;

  int n_vec = 0;
  int n_err = 0;

  operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK100MHZ(clk),
    .Reset    (Reset),
    .SW       (SW),
    .Center   (Center),
    .Ack      (Ack),
    .A        (A),
    .B        (B),
    .Valid    (Valid),
    .LED      (LED)
  );

  always #1 clk = ~clk;

  // Reference model: raw button samples since reset, the derived synchronized level history,
  // and the entry phase (0 = waiting for A, 1 = waiting for B, 2 = pair valid).
  bit          cen_hist[$];
  bit          s_hist[$];
  bit          m_deb, m_press, model_live;
  int          m_phase;
  logic [15:0] m_a, m_b;

  initial model_live = 1'b0;

  always @(posedge clk) begin
    bit s_now, pr_new, all_diff;
    if (Reset) begin
      cen_hist.delete();
      s_hist.delete();
      m_deb   = 1'b0;
      m_press = 1'b0;
      m_phase = 0;
      m_a     = 16'h0000;
      m_b     = 16'h0000;
    end else begin
      s_now = (cen_hist.size() >= 2) ? cen_hist[cen_hist.size()-2] : 1'b0;
      cen_hist.push_back(Center);
      s_hist.push_back(s_now);
      case (m_phase)
        0: if (m_press) begin m_a = SW; m_phase = 1; end
        1: if (m_press) begin m_b = SW; m_phase = 2; end
        2: if (Ack) m_phase = 0;
        default: m_phase = 0;
      endcase
      pr_new = 1'b0;
      if (DEB_EN) begin
        // The level flips once the last D synchronized samples all disagree with it.
        if (s_hist.size() >= D) begin
          all_diff = 1'b1;
          for (int k = 1; k <= D; k++)
            if (s_hist[s_hist.size()-k] == m_deb) all_diff = 1'b0;
          if (all_diff) begin
            m_deb  = !m_deb;
            pr_new = m_deb;
          end
        end
      end else begin
        pr_new = s_now && !((s_hist.size() >= 2) ? s_hist[s_hist.size()-2] : 1'b0);
        m_deb  = (cen_hist.size() >= 2) ? cen_hist[cen_hist.size()-2] : 1'b0;
      end
      m_press = pr_new;
    end
    model_live = 1'b1;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [36:0] exp_v, got_v;
    if (model_live) begin
      exp_v = {m_a, m_b, (m_phase == 2), m_deb, (m_phase == 2), (m_phase == 1), (m_phase == 0)};
      got_v = {A, B, Valid, LED};
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL model t=%0t got A=%h B=%h V=%b LED=%b want A=%h B=%h V=%b LED=%b",
                 $time, A, B, Valid, LED, exp_v[36:21], exp_v[20:5], exp_v[4], exp_v[3:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic do_reset();
    Reset  = 1'b1;
    Center = 1'b0;
    Ack    = 1'b0;
    tick(2);
    Reset  = 1'b0;
  endtask

  task automatic press_op(input logic [15:0] v);
    SW     = v;
    Center = 1'b1;
    tick(6);
    Center = 1'b0;
    tick(8);
  endtask

  initial begin
    Reset  = 1'b1;
    SW     = 16'hFFFF;
    Center = 1'b1;
    Ack    = 1'b0;
    tick(3);
    chk("rst_A", A, 16'h0000);
    chk("rst_B", B, 16'h0000);
    chk("rst_valid", {15'd0, Valid}, 16'h0000);
    chk("rst_led", {12'd0, LED}, 16'h0001);
    Reset = 1'b0;
    tick(CAP - 1);
    chk("rst_A_early", A, 16'h0000);
    tick(1);
    chk("rst_A_capture", A, 16'hFFFF);

    // Single capture and release
    do_reset();
    SW     = 16'h0002;
    Center = 1'b1;
    tick(CAP);
    chk("single_A", A, 16'h0002);
    chk("single_led", {12'd0, LED}, 16'h000A);
    tick(10 - CAP);
    Center = 1'b0;
    tick(12);
    chk("single_release_A", A, 16'h0002);
    chk("single_release_B", B, 16'h0000);
    chk("single_release_led", {12'd0, LED}, 16'h0002);

    // Short pulse and fast toggling
    do_reset();
    SW     = 16'h0BAD;
    Center = 1'b1;
    tick(3);
    Center = 1'b0;
    tick(12);
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    chk("glitch_A", A, 16'h0000);
    chk("glitch_led", {13'd0, LED[2:0]}, 16'h0001);
`else
    chk("short_pulse_A", A, 16'h0BAD);
    chk("short_pulse_led", {13'd0, LED[2:0]}, 16'h0002);
`endif
    for (int i = 0; i < 5; i++) begin
      Center = 1'b1;
      tick(2);
      Center = 1'b0;
      tick(2);
    end
    tick(10);
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    chk("toggle_A", A, 16'h0000);
    chk("toggle_led", {13'd0, LED[2:0]}, 16'h0001);
    do_reset();
    SW     = 16'h0777;
    Center = 1'b1;
    tick(D);
    Center = 1'b0;
    tick(10);
    chk("min_width_A", A, 16'h0777);
`endif

    // Full pair, frozen while valid, then acknowledge
    do_reset();
    press_op(16'h00F0);
    press_op(16'h000F);
    chk("pair_valid", {15'd0, Valid}, 16'h0001);
    chk("pair_A", A, 16'h00F0);
    chk("pair_B", B, 16'h000F);
    chk("pair_led", {13'd0, LED[2:0]}, 16'h0004);
    press_op(16'h5555);
    chk("frozen_A", A, 16'h00F0);
    chk("frozen_B", B, 16'h000F);
    Ack = 1'b1;
    tick(1);
    Ack = 1'b0;
    chk("ack_valid", {15'd0, Valid}, 16'h0000);
    chk("ack_led", {13'd0, LED[2:0]}, 16'h0001);
    chk("ack_keep_A", A, 16'h00F0);

    // Press and Ack on the same cycle: Ack wins, press discarded
    press_op(16'h1111);
    press_op(16'h2222);
    SW     = 16'h3333;
    Center = 1'b1;
    tick(CAP - 1);
    Ack    = 1'b1;
    tick(1);
    Ack    = 1'b0;
    chk("simul_led", {13'd0, LED[2:0]}, 16'h0001);
    tick(2);
    Center = 1'b0;
    tick(10);
    chk("simul_A", A, 16'h1111);
    chk("simul_led_after", {13'd0, LED[2:0]}, 16'h0001);

    // Ack held high throughout: pair consumed on its first valid cycle
    do_reset();
    Ack = 1'b1;
    press_op(16'h0A0A);
    press_op(16'h0B0B);
    chk("ackhold_valid", {15'd0, Valid}, 16'h0000);
    chk("ackhold_B", B, 16'h0B0B);
    Ack = 1'b0;

    // Reset while waiting for B, and reset coinciding with a press
    do_reset();
    press_op(16'h1234);
    chk("wb_A", A, 16'h1234);
    chk("wb_led", {13'd0, LED[2:0]}, 16'h0002);
    Reset = 1'b1;
    tick(1);
    chk("wb_rst_A", A, 16'h0000);
    chk("wb_rst_led", {12'd0, LED}, 16'h0001);
    Reset  = 1'b0;
    SW     = 16'h4321;
    Center = 1'b1;
    tick(CAP - 1);
    Reset  = 1'b1;
    Center = 1'b0;
    tick(1);
    Reset  = 1'b0;
    tick(10);
    chk("rst_press_A", A, 16'h0000);
    chk("rst_press_led", {12'd0, LED}, 16'h0001);

`ifndef OPERAND_ENTRY_DEBOUNCE_EN
    // One-cycle pulse accepted without the debouncer
    do_reset();
    SW     = 16'h00AA;
    Center = 1'b1;
    tick(1);
    Center = 1'b0;
    tick(2);
    chk("nodeb_A_early", A, 16'h0000);
    tick(1);
    chk("nodeb_A", A, 16'h00AA);
    chk("nodeb_led", {13'd0, LED[2:0]}, 16'h0002);
`endif

    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
# operand_entry

Front-end input controller for the Nexys board datapaths (subtractor and similar two-operand units). It debounces the `Center` push-button, captures the 16 slide switches as operand A on the first press and operand B on the second, then presents the pair with a valid/acknowledge handshake. It is the input-side counterpart of the arithmetic/display path: it feeds `A`/`B` to the arithmetic block and shows its own entry state on the LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable clocks required to accept a button level change (10 ms at 100 MHz). Legal range is ≥ 2.
- `CLK100MHZ` in 1: system clock; all logic is on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `SW` in 16: operand value from the slide switches.
- `Center` in 1: raw, asynchronous, bouncing push-button.
- `Ack` in 1: consumer accepts the current operand pair.
- `A` out 16: captured operand A.
- `B` out 16: captured operand B.
- `Valid` out 1: the operand pair is complete and stable.
- `LED` out 4: status. Bit 0 = WAIT_A, bit 1 = WAIT_B, bit 2 = VALID, bit 3 = debounced button level.

## Operation
- **Synchronizer.** `Center` passes through a 2-flop synchronizer to produce `s`.
- **Debouncer.** Debounced level `deb` and counter `cnt`, with `cnt` sized to `$clog2(DEBOUNCE_CYCLES)`.
  - If `s == deb`, then `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, then `deb <= s` and `cnt <= 0`.
  - Otherwise, `cnt <= cnt+1`.
  - Any bounce back to `deb` restarts the count.
- **Press pulse.** `press` is a registered 1-cycle pulse, set on the same edge where `deb` goes 0→1. Release (1→0) produces no pulse.
- **FSM states:** WAIT_A (reset state), WAIT_B, VALID.
  - WAIT_A with `press`: `A <= SW`, go to WAIT_B.
  - WAIT_B with `press`: `B <= SW`, go to VALID.
  - VALID: `Valid = 1`. `A` and `B` are frozen, and presses are ignored and discarded. When `Ack` is sampled 1, go to WAIT_A; `A` and `B` keep their values until overwritten.
  - `Ack` has no effect outside VALID.
- **Outputs.** `Valid` and `LED[2:0]` are registered decodes of the state.
- **Reset values:** `A = 0`, `B = 0`, `Valid = 0`, `LED = 4'b0001`, state WAIT_A, `deb = 0`, `cnt = 0`, synchronizer flops = 0, `press = 0`.
- **Reset mid-operation.** Reset overrides everything in the same cycle, including a pending `press` or `Ack`. After reset, a button already held down is accepted only after a full debounce interval (because `deb = 0`).

## Timing
- **Edge numbering.** Edge 1 is the first rising edge at which `Center` is sampled high.
  - `s` = 1 after edge 2.
  - `deb` and `press` = 1 after edge 2+`DEBOUNCE_CYCLES`.
  - `A` (or `B`) updates at edge 3+`DEBOUNCE_CYCLES`.
  - State and `LED` update on that same edge.
  - `Valid` rises on the edge that captures `B`.
- **Minimum press width.** `Center` must be high for at least `DEBOUNCE_CYCLES` consecutive sampled edges (ignoring synchronizer delay); shorter pulses are rejected.
- **Handshake.** `Valid` falls on the edge that samples `Ack` = 1. Holding `Ack` high continuously is legal, and the pair is then consumed on the first VALID cycle.
- **Simultaneous events.** `press` and `Ack` in the same VALID cycle: `Ack` is honoured and `press` is dropped. The next press is needed to capture A.
- **Back-to-back presses.** Presses separated by a release shorter than the debounce interval do not produce a second `press`.

## Configuration
- `OPERAND_ENTRY_DEBOUNCE_EN` defined: debouncer present, behaviour as above.
- Not defined: debouncer removed, `deb` = `s` directly, and `press <= s & ~s_q` with `s_q` a 1-flop delay.
  - `A` updates at edge 4 after `Center` is sampled high.
  - A 1-cycle `Center` pulse is accepted.
  - `DEBOUNCE_CYCLES` is unused.
  - `LED[3]` = `s`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and a 2 ns clock.
- **Reset.** Assert `Reset` for 3 cycles with `SW=16'hFFFF` and `Center=1` → `A=0`, `B=0`, `Valid=0`, `LED=4'b0001` during reset. After release, `A=16'hFFFF` appears exactly 7 edges later.
- **Single capture.** `SW=16'h0002`, `Center` high for 10 cycles → `A=16'h0002` at edge 7, `LED=4'b1010`. Releasing the button produces no further capture.
- **Glitch rejection.** `Center` high for 3 cycles, or toggling every 2 cycles for 20 cycles → `A` unchanged and state stays WAIT_A.
- **Full pair and handshake.**
  - Press with `SW=16'h00F0`, then with `SW=16'h000F` → `Valid=1`, `A=16'h00F0`, `B=16'h000F`, `LED[2:0]=3'b100`.
  - Changing `SW` and pressing again while VALID → `A` and `B` unchanged.
  - Pulse `Ack` for 1 cycle → `Valid=0` on the next edge, `LED[2:0]=3'b001`.
- **Reset in WAIT_B.** Capture `A=16'h1234`, then assert `Reset` → `A=0`, WAIT_A. Assert `Reset` on the same edge as `press` → the reset takes effect and the press is dropped.
- **Macro undefined.** 1-cycle `Center` pulse with `SW=16'h00AA` → `A=16'h00AA` at edge 4, state WAIT_B.
